fetch_stage: RTL

- Instruction-fetch stage of the RISCyMCU core; sits directly upstream of the IF/ID pipeline register and produces the PC/instruction pair that register captures.
- Owns the program counter and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Holds each fetched instruction until the decode side accepts it.
- Applies branch/jump redirects, discarding any in-flight or buffered fetch.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared state encoding and constants for the RISCyMCU instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and holds each fetched instruction until the IF/ID register takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request driven at pc, waiting for gnt
// ST_WAIT  | request accepted, waiting for rvalid
// ST_HOLD  | instruction presented on if_*, waiting for id_ready
// ST_KILL  | one response still owed by memory; it will be dropped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    input  logic                   id_ready_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   if_valid_o,
    output logic [ADDR_WIDTH-1:0]  if_pc_o,
    output logic [ADDR_WIDTH-1:0]  if_pc_plus4_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

    fetch_state_e           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  req_pc_q;
    logic                   if_valid_q;
    logic [ADDR_WIDTH-1:0]  if_pc_q;
    logic [ADDR_WIDTH-1:0]  if_pc_plus4_q;
    logic [INSTR_WIDTH-1:0] if_instr_q;

    logic [ADDR_WIDTH-1:0]  redirect_pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_plus4_d;

    assign redirect_pc_d  = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign req_pc_plus4_d = req_pc_q + ADDR_WIDTH'(4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_instr_q    <= NOP;
        end else if (redirect_valid_i) begin
            // A redirect wins over gnt/rvalid/id_ready; any response it orphans goes to KILL.
            pc_q <= redirect_pc_d;
            case (state_q)
                ST_FETCH: begin
                    if (imem_gnt_i) state_q <= ST_KILL;
                end
                ST_WAIT: begin
                    state_q <= imem_rvalid_i ? ST_FETCH : ST_KILL;
                end
                ST_HOLD: begin
                    if_valid_q <= 1'b0;
                    if_instr_q <= NOP;
                    state_q    <= ST_FETCH;
                end
                ST_KILL: begin
                    if (imem_rvalid_i) state_q <= ST_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_gnt_i) begin
                        req_pc_q <= pc_q;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if_instr_q    <= imem_rdata_i;
                        if_pc_q       <= req_pc_q;
                        if_pc_plus4_q <= req_pc_plus4_d;
                        if_valid_q    <= 1'b1;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready_i) begin
                        pc_q       <= if_pc_plus4_q;
                        if_valid_q <= 1'b0;
                        if_instr_q <= NOP;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if (imem_rvalid_i) state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Gated with reset so no request leaks out while the core is held in reset.
    assign imem_req_o    = rst_ni && (state_q == ST_FETCH);
    assign imem_addr_o   = pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_pc_o       = if_pc_q;
    assign if_pc_plus4_o = if_pc_plus4_q;
    assign if_instr_o    = if_instr_q;

endmodule
